scan_ring_counter: RTL

SCAN_RING_COUNTER -- requirements
Module: scan_ring_counter

---
 rtl/scan_pkg.sv | 38 +++
 rtl/scan_tick_gen.sv | 35 +++
 rtl/scan_ring_counter.sv | 83 ++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared helpers for the digit scanner: next-enabled-digit search and
// output polarity mapping. Sized for the widest legal scan (16 digits).
package scan_pkg;

  localparam int unsigned MAX_DIGITS = 16;

  // Nearest index after cur (stepping by dir: 0 = up, 1 = down, modulo n)
  // whose mask bit is set. Stepping n places lands back on cur, so a mask
  // with only the current digit set keeps cur; an empty mask also keeps cur.
  function automatic logic [3:0] next_enabled(input logic [3:0]  cur,
                                              input logic [15:0] mask,
                                              input logic        dir,
                                              input int unsigned n);
    logic [3:0]  res;
    logic        found;
    int unsigned cand;
    res   = cur;
    found = 1'b0;
    for (int unsigned step = 1; step <= MAX_DIGITS; step++) begin
      if (!found && step <= n) begin
        if (dir) cand = (32'(cur) + n - step) % n;
        else     cand = (32'(cur) + step) % n;
        if (mask[cand[3:0]]) begin
          res   = cand[3:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Map an active-high one-hot vector onto the pad polarity.
  function automatic logic [15:0] apply_pol(input logic [15:0] v,
                                            input logic        active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..PRESCALE-1 while enabled, held at 0 otherwise.
// Exposes the next count (so callers can register outputs aligned with it)
// and a strobe marking the cycle whose edge ends the slot.
module scan_tick_gen #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          en_i,
  output logic [$clog2(PRESCALE)-1:0]   cnt_next_o,
  output logic                          wrap_o
);

  localparam int unsigned CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear while disabled, wrap at the end of the slot.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = en_i && (cnt_q == CW'(PRESCALE - 1));
    if (!en_i)       cnt_d = '0;
    else if (wrap_o) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  // Prescale counter register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/scan_ring_counter.sv
// Multiplexed display digit scanner: steps through enabled digits one slot
// at a time, blanking the drive for the first cycles of each slot.
module scan_ring_counter
  import scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                                        clk_i,
  input  logic                                        reset_ni,
  input  logic                                        en_i,
  input  logic                                        dir_i,
  input  logic [NUM_DIGITS-1:0]                       mask_i,
  output logic [NUM_DIGITS-1:0]                       sel_o,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] idx_o,
  output logic                                        tick_o
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]         cnt_d;
  logic                  wrap;
  logic                  past_blank;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  tick_q;

  scan_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .en_i       (en_i),
    .cnt_next_o (cnt_d),
    .wrap_o     (wrap)
  );

  // Blanking window is judged on the count the registers are about to hold.
  if (BLANK_CYCLES == 0) begin : g_noblank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (cnt_d >= CW'(BLANK_CYCLES));
  end

  // Next digit index and the registered drive pattern that goes with it.
  always_comb begin
    logic [15:0] mask_ext;
    logic [15:0] onehot;
    logic [15:0] pol;
    logic [3:0]  nxt;
    mask_ext               = '0;
    mask_ext[NUM_DIGITS-1:0] = mask_i;
    nxt   = next_enabled(4'(idx_q), mask_ext, dir_i, NUM_DIGITS);
    idx_d = wrap ? nxt[IW-1:0] : idx_q;
    onehot = '0;
    if (en_i && past_blank && mask_ext[4'(idx_d)]) onehot[4'(idx_d)] = 1'b1;
    pol   = apply_pol(onehot, ACTIVE_LOW);
    sel_d = pol[NUM_DIGITS-1:0];
  end

  // Index, drive and slot-start pulse registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q  <= '0;
      sel_q  <= SEL_IDLE;
      tick_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      tick_q <= wrap;
    end
  end

  assign sel_o  = sel_q;
  assign idx_o  = idx_q;
  // The pulse is suppressed if scanning is stopped during its cycle.
  assign tick_o = tick_q & en_i;

endmodule
